fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.

---
 rtl/fifo_wr_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Packets stay atomic up to MAX_BURST beats; wfull stalls beats, wfull_almost gates new grants.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 16,
  parameter int SCW       = 16
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  input  logic                     wfull_almost,
  output logic                     winc,
  output logic [DSIZE-1:0]         wdata,
  output logic [NREQ-1:0]          gnt_onehot,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy,
  output logic [SCW-1:0]           stall_cnt
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d, last_q, last_d, pick_id;
  logic [NREQ-1:0]  gnt_oh_q, gnt_oh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SCW-1:0]   stall_q, stall_d;
  logic             pick_vld, own_valid, beat_end;
  int               idx;

  assign busy       = (state_q == BURST);
  assign gnt_onehot = gnt_oh_q;
  assign gnt_id     = gnt_id_q;
  assign stall_cnt  = stall_q;
  assign own_valid  = req_valid[gnt_id_q];
  // Nothing is written in a reset cycle, even if a burst was in flight.
  assign winc       = busy & own_valid & ~wfull & ~wrst;
  assign wdata      = req_data[int'(gnt_id_q)*DSIZE +: DSIZE];
  assign req_ready  = (busy & ~wfull & ~wrst) ? gnt_oh_q : '0;
  assign beat_end   = winc & (req_last[gnt_id_q] | (cnt_q == CW'(MAX_BURST - 1)));

  // Search starts after last_owner and reaches last_owner itself last, so the
  // ending owner is only re-picked at handoff when it is the sole valid requester.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NREQ;
      if (req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    gnt_oh_d = gnt_oh_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    if (busy && own_valid && wfull && !(&stall_q)) stall_d = stall_q + 1'b1;
    if (winc) cnt_d = cnt_q + 1'b1;
    if (!busy || beat_end) begin
      if (pick_vld && !wfull_almost) begin
        state_d  = BURST;
        gnt_id_d = pick_id;
        gnt_oh_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
        last_d   = pick_id;
        cnt_d    = '0;
      end else begin
        state_d  = IDLE;
        gnt_oh_d = '0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      gnt_oh_q <= '0;
      last_q   <= IDW'(NREQ - 1);
      cnt_q    <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      gnt_oh_q <= gnt_oh_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, randomized run against a reference model,
// and a long-packet sequence with a full stall.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DSIZE = 8, MAX_BURST = 16, SCW = 16;
  localparam longint SMAX = (64'd1 << SCW) - 1;

  logic                    wclk = 1'b0;
  logic                    wrst;
  logic [NREQ-1:0]         req_valid, req_last, req_ready;
  logic [NREQ*DSIZE-1:0]   req_data;
  logic                    wfull, wfull_almost, winc, busy;
  logic [DSIZE-1:0]        wdata;
  logic [NREQ-1:0]         gnt_onehot;
  logic [1:0]              gnt_id;
  logic [SCW-1:0]          stall_cnt;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .SCW(SCW)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wfull(wfull),
    .wfull_almost(wfull_almost), .winc(winc), .wdata(wdata),
    .gnt_onehot(gnt_onehot), .gnt_id(gnt_id), .busy(busy), .stall_cnt(stall_cnt)
  );

  int n_chk = 0, n_pass = 0;

  // Reference model: owner index (-1 = idle), beats in current grant, rr pointer, stall total.
  int     m_owner = -1, m_beats = 0, m_last = NREQ - 1;
  longint m_stall = 0;

  // Values observed at the last sampling point.
  logic            o_winc, o_busy;
  logic [1:0]      o_id;
  logic [7:0]      o_wdata;
  logic [NREQ-1:0] o_gnt, o_rdy, o_acc;
  logic [SCW-1:0]  o_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
  endtask

  // One clock: sample at negedge, compare with the model, advance the model, move past posedge.
  task automatic step();
    bit              m_busy, e_winc, ended;
    int              ow, pick, nval, c;
    logic [NREQ-1:0] e_rdy, e_gnt;
    @(negedge wclk);
    o_winc = winc; o_busy = busy; o_id = gnt_id; o_wdata = wdata;
    o_gnt = gnt_onehot; o_rdy = req_ready; o_stall = stall_cnt;
    o_acc = req_valid & req_ready;
    m_busy = (m_owner >= 0);
    ow     = m_busy ? m_owner : 0;
    e_winc = !wrst && m_busy && req_valid[ow] && !wfull;
    e_gnt  = m_busy ? NREQ'(1 << ow) : '0;
    e_rdy  = (m_busy && !wfull && !wrst) ? e_gnt : '0;
    chk("m_winc", o_winc, e_winc);
    chk("m_busy", o_busy, m_busy);
    chk("m_gnt", o_gnt, e_gnt);
    chk("m_ready", o_rdy, e_rdy);
    chk("m_stall", o_stall, m_stall);
    if (m_busy) chk("m_gnt_id", o_id, ow);
    if (e_winc) chk("m_wdata", o_wdata, req_data[ow*DSIZE +: DSIZE]);
    if (wrst) begin
      m_owner = -1; m_beats = 0; m_last = NREQ - 1; m_stall = 0;
    end else begin
      ended = 1'b0;
      if (m_busy) begin
        if (req_valid[ow] && wfull && m_stall < SMAX) m_stall++;
        if (e_winc) begin
          m_beats++;
          ended = req_last[ow] || (m_beats == MAX_BURST);
        end
      end
      if (!m_busy || ended) begin
        pick = -1;
        nval = $countones(req_valid);
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (pick < 0 && req_valid[c] && !(ended && c == ow && nval > 1)) pick = c;
        end
        if (pick >= 0 && !wfull_almost) begin
          m_owner = pick; m_last = pick; m_beats = 0;
        end else m_owner = -1;
      end
    end
    @(posedge wclk);
    #1;
  endtask

  typedef struct {
    bit rst; logic [3:0] v; logic [3:0] l; bit full; bit alm;
    bit winc; logic [3:0] gnt; bit busy; int stall; logic [3:0] rdy;
  } vec_t;

  vec_t tbl[21];
  logic [9:0] log_q[$];
  logic [9:0] exp_q[$];
  int seq1, seq2, fcnt, full_wincs;

  initial begin
    //             rst v     l     full alm | winc gnt  busy stall rdy
    tbl[0]  = '{1, 4'hF, 4'hF, 0, 0,  0, 4'h0, 0, 0, 4'h0};
    tbl[1]  = '{1, 4'hF, 4'hF, 0, 0,  0, 4'h0, 0, 0, 4'h0};
    tbl[2]  = '{0, 4'hF, 4'hF, 0, 0,  0, 4'h0, 0, 0, 4'h0};
    tbl[3]  = '{0, 4'hF, 4'hF, 0, 0,  1, 4'h1, 1, 0, 4'h1};
    tbl[4]  = '{0, 4'hF, 4'hF, 0, 0,  1, 4'h2, 1, 0, 4'h2};
    tbl[5]  = '{0, 4'hF, 4'hF, 0, 0,  1, 4'h4, 1, 0, 4'h4};
    tbl[6]  = '{0, 4'hF, 4'hF, 0, 0,  1, 4'h8, 1, 0, 4'h8};
    tbl[7]  = '{0, 4'hF, 4'hF, 0, 0,  1, 4'h1, 1, 0, 4'h1};
    tbl[8]  = '{0, 4'h0, 4'h0, 0, 0,  0, 4'h2, 1, 0, 4'h2};
    tbl[9]  = '{0, 4'h2, 4'h2, 0, 1,  1, 4'h2, 1, 0, 4'h2};
    tbl[10] = '{0, 4'h4, 4'h0, 0, 1,  0, 4'h0, 0, 0, 4'h0};
    tbl[11] = '{0, 4'h4, 4'h0, 0, 1,  0, 4'h0, 0, 0, 4'h0};
    tbl[12] = '{0, 4'h4, 4'h0, 0, 0,  0, 4'h0, 0, 0, 4'h0};
    tbl[13] = '{0, 4'h4, 4'h0, 0, 1,  1, 4'h4, 1, 0, 4'h4};
    tbl[14] = '{0, 4'h4, 4'h0, 1, 0,  0, 4'h4, 1, 0, 4'h0};
    tbl[15] = '{0, 4'h4, 4'h4, 1, 0,  0, 4'h4, 1, 1, 4'h0};
    tbl[16] = '{0, 4'hC, 4'h4, 0, 0,  1, 4'h4, 1, 2, 4'h4};
    tbl[17] = '{0, 4'h8, 4'h8, 0, 0,  1, 4'h8, 1, 2, 4'h8};
    tbl[18] = '{0, 4'h0, 4'h0, 0, 0,  0, 4'h8, 1, 2, 4'h8};
    tbl[19] = '{1, 4'h8, 4'h0, 0, 0,  0, 4'h8, 1, 2, 4'h0};
    tbl[20] = '{0, 4'h0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 4'h0};

    wrst = 1'b1; req_valid = '1; req_last = '1; wfull = 1'b0; wfull_almost = 1'b0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(posedge wclk);
    #1;

    // Reset, fairness, almost-full gate, last+full collision, reset mid-burst.
    for (int r = 0; r < 21; r++) begin
      wrst = tbl[r].rst; req_valid = tbl[r].v; req_last = tbl[r].l;
      wfull = tbl[r].full; wfull_almost = tbl[r].alm;
      step();
      chk($sformatf("tbl%0d_winc", r), o_winc, tbl[r].winc);
      chk($sformatf("tbl%0d_gnt", r), o_gnt, tbl[r].gnt);
      chk($sformatf("tbl%0d_busy", r), o_busy, tbl[r].busy);
      chk($sformatf("tbl%0d_stall", r), o_stall, tbl[r].stall);
      chk($sformatf("tbl%0d_ready", r), o_rdy, tbl[r].rdy);
      if (tbl[r].winc) chk($sformatf("tbl%0d_wdata", r), o_wdata, 8'hA0 + 8'(o_id));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      wrst         = ($urandom_range(199) == 0);
      req_valid    = NREQ'($urandom);
      req_last     = NREQ'($urandom & $urandom);
      wfull        = ($urandom_range(4) == 0);
      wfull_almost = ($urandom_range(5) == 0);
      req_data     = $urandom;
      step();
    end

    // Long packet from req1 split at MAX_BURST, req2 served in between, 5-cycle full stall.
    wrst = 1'b1; req_valid = '0; req_last = '0; wfull = 1'b0; wfull_almost = 1'b0;
    step();
    wrst = 1'b0;
    seq1 = 0; seq2 = 0; fcnt = 0; full_wincs = 0;
    for (int cyc = 0; cyc < 300 && seq1 < 40; cyc++) begin
      req_valid = {1'b0, seq2 < 3, seq1 < 40, 1'b0};
      req_last  = {1'b0, seq2 == 2, seq1 == 39, 1'b0};
      req_data  = {8'h00, 8'(128 + seq2), 8'(64 + seq1), 8'h00};
      wfull     = (seq1 == 5 && fcnt < 5);
      step();
      if (o_winc) log_q.push_back({o_id, o_wdata});
      if (wfull) begin
        fcnt++;
        if (o_winc || o_rdy != 0) full_wincs++;
      end
      if (o_acc[1]) seq1++;
      if (o_acc[2]) seq2++;
    end
    req_valid = '0;
    chk("t3_done", seq1, 40);
    chk("t4_full_cycles", fcnt, 5);
    chk("t4_no_write_in_full", full_wincs, 0);
    chk("t4_stall_total", stall_cnt, 5);
    for (int k = 0; k < 16; k++) exp_q.push_back({2'd1, 8'(64 + k)});
    for (int k = 0; k < 3; k++)  exp_q.push_back({2'd2, 8'(128 + k)});
    for (int k = 16; k < 40; k++) exp_q.push_back({2'd1, 8'(64 + k)});
    chk("t3_len", log_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
      chk($sformatf("t3_beat%0d", k), log_q[k], exp_q[k]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
